// File: rtl/loc_stack_pkg.sv
// Package: loc_stack_pkg
// Purpose: Types and default sizes that the location-stack replay block
//          and its register file share.
// Contents:
//   state_t    FSM state: ST_STACK (normal LIFO use) and ST_REPLAY (path replay)
//   LOC_WIDTH  default bits per location entry
//   LOC_DEPTH  default number of entries (a power of two, >= 2)
package loc_stack_pkg;

  typedef enum logic {
    ST_STACK  = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  localparam int LOC_WIDTH = 8;
  localparam int LOC_DEPTH = 16;

endpackage

// File: rtl/loc_stack_mem.sv
// Module: loc_stack_mem
// Purpose: DEPTH x WIDTH register file that backs the location stack.
//          It has one synchronous write port and two asynchronous read ports.
// Ports:
//   clk       in   rising-edge clock
//   we        in   write enable
//   waddr     in   write address
//   wdata     in   write data
//   top_addr  in   read address for the entry below the top (used on pop)
//   top_data  out  mem[top_addr], combinational
//   rep_addr  in   replay read address
//   rep_data  out  mem[rep_addr], combinational
module loc_stack_mem
  import loc_stack_pkg::*;
#(
  parameter int WIDTH = LOC_WIDTH,
  parameter int DEPTH = LOC_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    top_addr,
  output logic [WIDTH-1:0] top_data,
  input  logic [AW-1:0]    rep_addr,
  output logic [WIDTH-1:0] rep_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset. Nothing reads an entry before
  // that entry is written, and a reset would only add a load path to every bit.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign top_data = mem[top_addr];
  assign rep_data = mem[rep_addr];

endmodule

// File: rtl/loc_stack_replay.sv
// Module: loc_stack_replay
// Purpose: LIFO of maze locations for the path-search datapath. In STACK
//          mode, push and pop track the current path. A one-clock 'done'
//          pulse freezes the stack, and later pops replay the entries from
//          the bottom to the top (start -> goal).
// Build option: define LOC_STACK_ERR_EN to build the sticky 'err' flag.
//          Without it, err is tied to 0.
// Ports (reset 'rst' is synchronous and active low):
//   clk, rst   clock and reset
//   locIn      location to push
//   push, pop  stack requests (in REPLAY, pop advances the replay)
//   done       one-clock pulse that starts the replay
//   locOut     STACK: top entry; REPLAY: current replay entry
//   empStck    count == 0
//   fullStck   count == DEPTH (STACK mode only)
//   count      STACK: entries held; REPLAY: entries not yet replayed
//   replaying  high while in REPLAY
//   err        sticky illegal-operation flag
module loc_stack_replay
  import loc_stack_pkg::*;
#(
  parameter int WIDTH = LOC_WIDTH,
  parameter int DEPTH = LOC_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] locIn,
  input  logic             push,
  input  logic             pop,
  input  logic             done,
  output logic [WIDTH-1:0] locOut,
  output logic             empStck,
  output logic             fullStck,
  output logic [AW:0]      count,
  output logic             replaying,
  output logic             err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t           state;
  logic [AW:0]      sp;      // number of entries held; the next free slot
  logic [AW-1:0]    rp;      // replay index, counted from the bottom
  logic [AW:0]      sp_m1;
  logic [AW:0]      sp_m2;
  logic             empty;
  logic             full;
  logic             start_replay;
  logic             replace;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    rep_addr;
  logic [WIDTH-1:0] top_data;
  logic [WIDTH-1:0] rep_data;

  assign sp_m1 = sp - 1'b1;
  assign sp_m2 = sp - 2'd2;
  assign empty = (sp == '0);
  assign full  = (sp == FULL_CNT);

  // In STACK mode, done with a non-empty stack takes priority over push and pop.
  assign start_replay = (state == ST_STACK) && done && !empty;
  assign replace      = push && pop && !empty;

  // NOTE: each combinational output gets a default first, so that no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    we    = 1'b0;
    waddr = sp[AW-1:0];
    if (state == ST_STACK && !start_replay) begin
      if (replace) begin
        we    = 1'b1;
        waddr = sp_m1[AW-1:0];
      end else if (push && !full) begin
        we = 1'b1;
      end
    end
  end

  // Entering REPLAY reads entry 0. Each replay advance reads the next entry up.
  assign rep_addr = (state == ST_REPLAY) ? rp + 1'b1 : '0;

  loc_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .we       (we),
    .waddr    (waddr),
    .wdata    (locIn),
    .top_addr (sp_m2[AW-1:0]),
    .top_data (top_data),
    .rep_addr (rep_addr),
    .rep_data (rep_data)
  );

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples values from before the edge, whatever the order
  // of the statements.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_STACK;
      sp        <= '0;
      rp        <= '0;
      locOut    <= '0;
      empStck   <= 1'b1;
      fullStck  <= 1'b0;
      count     <= '0;
      replaying <= 1'b0;
    end else begin
      case (state)
        ST_STACK: begin
          if (start_replay) begin
            state     <= ST_REPLAY;
            rp        <= '0;
            locOut    <= rep_data;
            replaying <= 1'b1;
            fullStck  <= 1'b0;
            count     <= sp;
          end else if (replace) begin
            locOut <= locIn;
          end else if (push && !full) begin
            // This branch also covers push+pop on an empty stack (push only).
            sp       <= sp + 1'b1;
            locOut   <= locIn;
            count    <= sp + 1'b1;
            empStck  <= 1'b0;
            fullStck <= (sp == FULL_CNT - 1'b1);
          end else if (pop && !push && !empty) begin
            sp       <= sp_m1;
            locOut   <= (sp_m1 == '0) ? '0 : top_data;
            count    <= sp_m1;
            empStck  <= (sp_m1 == '0);
            fullStck <= 1'b0;
          end
        end
        ST_REPLAY: begin
          if (pop) begin
            if ({1'b0, rp} == sp_m1) begin
              state     <= ST_STACK;
              sp        <= '0;
              rp        <= '0;
              locOut    <= '0;
              empStck   <= 1'b1;
              count     <= '0;
              replaying <= 1'b0;
            end else begin
              rp     <= rp + 1'b1;
              locOut <= rep_data;
              count  <= sp - {1'b0, rp} - 1'b1;
            end
          end
        end
        default: state <= ST_STACK;
      endcase
    end
  end

`ifdef LOC_STACK_ERR_EN
  logic illegal;

  always_comb begin
    illegal = 1'b0;
    if (state == ST_REPLAY) begin
      illegal = push;
    end else if (!start_replay) begin
      illegal = (push && !pop && full) || (pop && !push && empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)         err <= 1'b0;
    else if (illegal) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
